msf_digit_scanner: RTL and testbench

//  Time-multiplexed display scanner for the MSF clock. Snapshots the decoded time/date BCD fields
//  and scans them out one digit per step, so all digits share a narrow output bus.

---
 rtl/msf_digit_scanner_if.sv | 37 +++
 rtl/msf_digit_scanner.sv | 125 ++++++++++++
 tb/tb_msf_digit_scanner.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/msf_digit_scanner_if.sv
// Bus bundle for the MSF display scanner: decoded BCD fields in, one scanned digit out.
interface msf_digit_scanner_if;
  logic       snap_i;
  logic [1:0] mode_i;
  logic [1:0] hour_h_i;
  logic [3:0] hour_l_i;
  logic [2:0] minute_h_i;
  logic [3:0] minute_l_i;
  logic [2:0] second_h_i;
  logic [3:0] second_l_i;
  logic [1:0] day_h_i;
  logic [3:0] day_l_i;
  logic       month_h_i;
  logic [3:0] month_l_i;
  logic [3:0] year_h_i;
  logic [3:0] year_l_i;
  logic [3:0] digit_o;
  logic [2:0] digit_sel_o;
  logic       strobe_o;
  logic       frame_o;
  logic       showing_date_o;
  logic       locked_o;

  // Drives the fields and mode, observes the scanned digit.
  modport master (
    output snap_i, mode_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i, second_h_i, second_l_i,
           day_h_i, day_l_i, month_h_i, month_l_i, year_h_i, year_l_i,
    input  digit_o, digit_sel_o, strobe_o, frame_o, showing_date_o, locked_o
  );

  // The scanner itself.
  modport slave (
    input  snap_i, mode_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i, second_h_i, second_l_i,
           day_h_i, day_l_i, month_h_i, month_l_i, year_h_i, year_l_i,
    output digit_o, digit_sel_o, strobe_o, frame_o, showing_date_o, locked_o
  );
endinterface

// File: rtl/msf_digit_scanner.sv
// Time-multiplexed display scanner: snapshots the decoded time/date fields and scans one digit
// per step onto a shared 4-bit bus. Page, mode, blanking and data are frozen per frame.
module msf_digit_scanner #(
  parameter int unsigned SCAN_DIV       = 1024,
  parameter int unsigned ALT_FRAMES     = 8,
  parameter bit          BLANK_UNLOCKED = 1'b1
) (
  input logic                clk_i,
  input logic                rst_i,
  msf_digit_scanner_if.slave bus
);
  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned AltW = (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [AltW-1:0] AltMax = AltW'(ALT_FRAMES - 1);

  typedef enum logic [1:0] {ModeTime, ModeDate, ModeAuto, ModeBlank} mode_e;

  // Nibbles 0..5 are the time page, 6..11 the date page, each zero-extended.
  logic [11:0][3:0] fields_in;
  logic [11:0][3:0] cap_q, cap_d, shadow_q, shadow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AltW-1:0]  alt_q, alt_d;
  logic [2:0]       sel_q, sel_d;
  logic [3:0]       digit_q, digit_d, idx;
  mode_e            fmode_q, fmode_d;
  logic             locked_q, locked_d, page_q, page_d, blank_q, blank_d, date_q, date_d;
  logic             strobe_q, strobe_d, frame_q, frame_d, tc, boundary;

  // Pack the incoming BCD fields in display order.
  always_comb begin
    fields_in[0]  = {2'b0, bus.hour_h_i};
    fields_in[1]  = bus.hour_l_i;
    fields_in[2]  = {1'b0, bus.minute_h_i};
    fields_in[3]  = bus.minute_l_i;
    fields_in[4]  = {1'b0, bus.second_h_i};
    fields_in[5]  = bus.second_l_i;
    fields_in[6]  = {2'b0, bus.day_h_i};
    fields_in[7]  = bus.day_l_i;
    fields_in[8]  = {3'b0, bus.month_h_i};
    fields_in[9]  = bus.month_l_i;
    fields_in[10] = bus.year_h_i;
    fields_in[11] = bus.year_l_i;
  end

  // Next-state: prescaler, digit index, capture, and per-frame shadow/mode/page latching.
  always_comb begin
    tc       = (cnt_q == CntMax);
    boundary = tc && (sel_q == 3'd5);
    cnt_d    = tc ? '0 : cnt_q + 1'b1;
    sel_d    = sel_q;
    if (tc) sel_d = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
    cap_d    = bus.snap_i ? fields_in : cap_q;
    locked_d = locked_q | bus.snap_i;
    shadow_d = shadow_q;
    fmode_d  = fmode_q;
    alt_d    = alt_q;
    page_d   = page_q;
    blank_d  = blank_q;
    date_d   = date_q;
    if (boundary) begin
      // A snap landing on the boundary edge goes straight to the shadow so it is not lost.
      shadow_d = bus.snap_i ? fields_in : cap_q;
      fmode_d  = mode_e'(bus.mode_i);
      if (fmode_d == ModeAuto) begin
        if (fmode_q != ModeAuto) begin
          alt_d  = '0;
          page_d = 1'b0;
        end else if (alt_q == AltMax) begin
          alt_d  = '0;
          page_d = ~page_q;
        end else begin
          alt_d  = alt_q + 1'b1;
        end
      end
      date_d  = (fmode_d == ModeDate) || ((fmode_d == ModeAuto) && page_d);
      blank_d = (fmode_d == ModeBlank) || (BLANK_UNLOCKED && !locked_q);
    end
    idx      = date_d ? {1'b0, sel_d} + 4'd6 : {1'b0, sel_d};
    digit_d  = digit_q;
    if (tc) digit_d = blank_d ? 4'hF : shadow_d[idx];
    strobe_d = tc;
    frame_d  = boundary;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      sel_q    <= 3'd5;
      cap_q    <= '0;
      shadow_q <= '0;
      locked_q <= 1'b0;
      fmode_q  <= ModeTime;
      alt_q    <= '0;
      page_q   <= 1'b0;
      blank_q  <= 1'b1;
      date_q   <= 1'b0;
      digit_q  <= 4'hF;
      strobe_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      cap_q    <= cap_d;
      shadow_q <= shadow_d;
      locked_q <= locked_d;
      fmode_q  <= fmode_d;
      alt_q    <= alt_d;
      page_q   <= page_d;
      blank_q  <= blank_d;
      date_q   <= date_d;
      digit_q  <= digit_d;
      strobe_q <= strobe_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.digit_o        = digit_q;
  assign bus.digit_sel_o    = sel_q;
  assign bus.strobe_o       = strobe_q;
  assign bus.frame_o        = frame_q;
  assign bus.showing_date_o = date_q;
  assign bus.locked_o       = locked_q;
endmodule

// File: tb/tb_msf_digit_scanner.sv
// Bench for msf_digit_scanner: cycle-count model checked every cycle plus literal frame checks.
module tb_msf_digit_scanner;
  localparam int SD = 4;
  localparam int AF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  msf_digit_scanner_if bus ();

  msf_digit_scanner #(
    .SCAN_DIV      (SD),
    .ALT_FRAMES    (AF),
    .BLANK_UNLOCKED(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: everything derived from cycles since reset release and the frame rules.
  int m_n, m_sel, m_digit, m_strobe, m_frame, m_date, m_locked, m_prev_mode, m_auto_idx;
  int m_cap[12];
  int m_digits[6];
  int in_now[12];

  task automatic read_inputs();
    in_now[0]  = int'(bus.hour_h_i);
    in_now[1]  = int'(bus.hour_l_i);
    in_now[2]  = int'(bus.minute_h_i);
    in_now[3]  = int'(bus.minute_l_i);
    in_now[4]  = int'(bus.second_h_i);
    in_now[5]  = int'(bus.second_l_i);
    in_now[6]  = int'(bus.day_h_i);
    in_now[7]  = int'(bus.day_l_i);
    in_now[8]  = int'(bus.month_h_i);
    in_now[9]  = int'(bus.month_l_i);
    in_now[10] = int'(bus.year_h_i);
    in_now[11] = int'(bus.year_l_i);
  endtask

  task automatic model_reset();
    m_n = 0; m_sel = 5; m_digit = 15; m_strobe = 0; m_frame = 0; m_date = 0;
    m_locked = 0; m_prev_mode = 0; m_auto_idx = 0;
    for (int i = 0; i < 12; i++) m_cap[i] = 0;
    for (int i = 0; i < 6; i++) m_digits[i] = 15;
  endtask

  task automatic model_step();
    int k, md, blank;
    int src[12];
    read_inputs();
    m_n++;
    m_strobe = (m_n % SD == 0) ? 1 : 0;
    m_frame  = 0;
    if (m_strobe == 1) begin
      k = m_n / SD;
      m_sel = (k - 1) % 6;
      if (m_sel == 0) begin
        md = int'(bus.mode_i);
        for (int i = 0; i < 12; i++) src[i] = bus.snap_i ? in_now[i] : m_cap[i];
        if (md == 2) m_auto_idx = (m_prev_mode == 2) ? m_auto_idx + 1 : 0;
        m_date = (md == 1 || (md == 2 && ((m_auto_idx / AF) % 2 == 1))) ? 1 : 0;
        blank  = (md == 3 || m_locked == 0) ? 1 : 0;
        for (int i = 0; i < 6; i++) m_digits[i] = (blank == 1) ? 15 : src[m_date == 1 ? i + 6 : i];
        m_prev_mode = md;
        m_frame = 1;
      end
      m_digit = m_digits[m_sel];
    end
    if (bus.snap_i) begin
      for (int i = 0; i < 12; i++) m_cap[i] = in_now[i];
      m_locked = 1;
    end
  endtask

  // Compare process: every clock edge and every reset assertion.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
      #1;
      check("digit", int'(bus.digit_o), m_digit);
      check("sel", int'(bus.digit_sel_o), m_sel);
      check("strobe", int'(bus.strobe_o), m_strobe);
      check("frame", int'(bus.frame_o), m_frame);
      check("date", int'(bus.showing_date_o), m_date);
      check("locked", int'(bus.locked_o), m_locked);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int g_d[6];
  int g_dt[6];

  // Collect the digits of the next full frame, bounded in cycles.
  task automatic grab_frame();
    int guard, got;
    guard = 0;
    got = 0;
    do begin
      @(posedge clk); #2; guard++;
    end while (!(bus.strobe_o && bus.frame_o) && guard < 100);
    if (bus.frame_o) begin
      g_d[0] = int'(bus.digit_o); g_dt[0] = int'(bus.showing_date_o); got = 1;
      while (got < 6 && guard < 200) begin
        @(posedge clk); #2; guard++;
        if (bus.strobe_o) begin
          g_d[got] = int'(bus.digit_o); g_dt[got] = int'(bus.showing_date_o); got++;
        end
      end
    end
    check("grab_frame", got, 6);
  endtask

  task automatic expect_frame(input string name, input logic [23:0] digits, input int dt);
    grab_frame();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_d%0d", name, i), g_d[i], int'(digits[23-4*i -: 4]));
      check($sformatf("%s_dt%0d", name, i), g_dt[i], dt);
    end
  endtask

  task automatic set_fields(input int hh, hl, mh, ml, sh, sl, dh, dl, oh, ol, yh, yl);
    bus.hour_h_i = 2'(hh);   bus.hour_l_i = 4'(hl);
    bus.minute_h_i = 3'(mh); bus.minute_l_i = 4'(ml);
    bus.second_h_i = 3'(sh); bus.second_l_i = 4'(sl);
    bus.day_h_i = 2'(dh);    bus.day_l_i = 4'(dl);
    bus.month_h_i = 1'(oh);  bus.month_l_i = 4'(ol);
    bus.year_h_i = 4'(yh);   bus.year_l_i = 4'(yl);
  endtask

  task automatic snap_pulse();
    bus.snap_i = 1'b1;
    @(negedge clk);
    bus.snap_i = 1'b0;
  endtask

  initial begin
    bus.snap_i = 1'b0;
    bus.mode_i = 2'd0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // First strobe exactly SCAN_DIV clocks after release, index 0, blank.
    repeat (3) @(posedge clk);
    #2 check("pre_strobe", int'(bus.strobe_o), 0);
    @(posedge clk);
    #2;
    check("first_strobe", int'(bus.strobe_o), 1);
    check("first_sel", int'(bus.digit_sel_o), 0);
    check("first_frame", int'(bus.frame_o), 1);
    check("first_digit", int'(bus.digit_o), 15);
    check("first_locked", int'(bus.locked_o), 0);

    // Mid-frame snapshot shows from the next frame.
    repeat (5) @(negedge clk);
    set_fields(1, 2, 3, 4, 5, 6, 2, 5, 0, 7, 2, 3);
    snap_pulse();
    expect_frame("time", 24'h123456, 0);
    check("locked_after_snap", int'(bus.locked_o), 1);

    @(negedge clk);
    bus.mode_i = 2'd1;
    expect_frame("date", 24'h250723, 1);

    @(negedge clk);
    bus.mode_i = 2'd0;
    expect_frame("time2", 24'h123456, 0);

    // Switch to auto in the middle of a frame.
    repeat (10) @(negedge clk);
    bus.mode_i = 2'd2;
    expect_frame("auto0", 24'h123456, 0);
    expect_frame("auto1", 24'h123456, 0);
    expect_frame("auto2", 24'h250723, 1);
    expect_frame("auto3", 24'h250723, 1);
    expect_frame("auto4", 24'h123456, 0);
    expect_frame("auto5", 24'h123456, 0);

    // Snap in the terminal cycle of index 5 feeds the very next frame.
    @(negedge clk);
    bus.mode_i = 2'd0;
    repeat (3) @(negedge clk);
    bus.minute_l_i = 4'd9;
    snap_pulse();
    expect_frame("bypass", 24'h123956, 0);

    // Asynchronous reset mid-scan.
    repeat (7) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_locked", int'(bus.locked_o), 0);
    check("rst_sel", int'(bus.digit_sel_o), 5);
    check("rst_digit", int'(bus.digit_o), 15);
    check("rst_strobe", int'(bus.strobe_o), 0);
    check("rst_date", int'(bus.showing_date_o), 0);
    bus.mode_i = 2'd3;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_fields(0, 8, 1, 5, 0, 0, 0, 1, 0, 1, 2, 4);
    snap_pulse();
    expect_frame("blank_mode", 24'hFFFFFF, 0);
    check("relocked", int'(bus.locked_o), 1);
    @(negedge clk);
    bus.mode_i = 2'd0;
    expect_frame("after_rst", 24'h081500, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
